// File: rtl/pixel_combinator.sv
// pixel_combinator: walks the frame in raster order, fetches each pixel from whichever queue holds it, emits an ordered stream.
// Optional WAIT_HIT timeout with DEFAULT_COLOUR substitution is built when PIXEL_COMBINATOR_TIMEOUT_EN is defined.
//   state    | meaning
//   REQUEST  | publish (x,y) as the live check coordinate
//   WAIT_HIT | wait for a queue to claim the coordinate, capture its colour
//   OUTPUT   | present the pixel until the downstream handshake, then advance raster
module pixel_combinator #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  RBG_SIZE       = 24,
    parameter int                  NUM_QUEUES     = 4,
    parameter int                  IMAGE_WIDTH    = 640,
    parameter int                  IMAGE_HEIGHT   = 480,
    parameter int                  TIMEOUT_CYCLES = 1024,
    parameter logic [RBG_SIZE-1:0] DEFAULT_COLOUR = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
    input  logic [NUM_QUEUES-1:0]          hit_i,
    output logic [DATA_WIDTH-1:0]          xpixel_check,
    output logic [DATA_WIDTH-1:0]          ypixel_check,
    output logic                           check_valid,
    output logic [RBG_SIZE-1:0]            colour_o,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           sop,
    output logic                           eol,
    output logic                           eop,
    output logic [15:0]                    frame_count,
    output logic                           multi_hit
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    ,
    output logic                           timeout_err
`endif
);

    localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {REQUEST, WAIT_HIT, OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d;
    logic [YW-1:0]           y_q, y_d;
    logic [DATA_WIDTH-1:0]   xchk_d, ychk_d;
    logic                    check_valid_d, out_valid_d;
    logic [RBG_SIZE-1:0]     colour_d, sel_colour, cap_colour;
    logic                    sop_d, eol_d, eop_d, multi_hit_d, capture;
    logic [15:0]             frame_count_d;

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{DEFAULT_COLOUR, 32'(TIMEOUT_CYCLES)};
`endif

    // Lowest-index hit wins when several queues claim the same coordinate.
    always_comb begin
        sel_colour = '0;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            if (hit_i[k]) sel_colour = colour_i[k*RBG_SIZE +: RBG_SIZE];
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        xchk_d        = xpixel_check;
        ychk_d        = ypixel_check;
        check_valid_d = check_valid;
        colour_d      = colour_o;
        out_valid_d   = out_valid;
        sop_d         = sop;
        eol_d         = eol;
        eop_d         = eop;
        frame_count_d = frame_count;
        multi_hit_d   = multi_hit;
        capture       = 1'b0;
        cap_colour    = sel_colour;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err;
`endif
        unique case (state_q)
            REQUEST: begin
                xchk_d        = DATA_WIDTH'(x_q);
                ychk_d        = DATA_WIDTH'(y_q);
                check_valid_d = 1'b1;
                state_d       = WAIT_HIT;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
                tmo_cnt_d     = TW'(TIMEOUT_CYCLES - 1);
`endif
            end
            WAIT_HIT: begin
                capture = |hit_i;
                if ($countones(hit_i) > 1) multi_hit_d = 1'b1;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
                if (!capture && tmo_cnt_q == '0) begin
                    capture       = 1'b1;
                    cap_colour    = DEFAULT_COLOUR;
                    timeout_err_d = 1'b1;
                end else if (tmo_cnt_q != '0) begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
`endif
                if (capture) begin
                    colour_d      = cap_colour;
                    check_valid_d = 1'b0;
                    out_valid_d   = 1'b1;
                    sop_d         = (x_q == '0) && (y_q == '0);
                    eol_d         = (x_q == X_LAST);
                    eop_d         = (x_q == X_LAST) && (y_q == Y_LAST);
                    state_d       = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    sop_d       = 1'b0;
                    eol_d       = 1'b0;
                    eop_d       = 1'b0;
                    state_d     = REQUEST;
                    if (x_q != X_LAST) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = '0;
                        if (y_q != Y_LAST) begin
                            y_d = y_q + 1'b1;
                        end else begin
                            y_d           = '0;
                            frame_count_d = frame_count + 16'd1;
                        end
                    end
                end
            end
            default: state_d = REQUEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REQUEST;
            x_q          <= '0;
            y_q          <= '0;
            xpixel_check <= '0;
            ypixel_check <= '0;
            check_valid  <= 1'b0;
            colour_o     <= '0;
            out_valid    <= 1'b0;
            sop          <= 1'b0;
            eol          <= 1'b0;
            eop          <= 1'b0;
            frame_count  <= '0;
            multi_hit    <= 1'b0;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
            tmo_cnt_q    <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            xpixel_check <= xchk_d;
            ypixel_check <= ychk_d;
            check_valid  <= check_valid_d;
            colour_o     <= colour_d;
            out_valid    <= out_valid_d;
            sop          <= sop_d;
            eol          <= eol_d;
            eop          <= eop_d;
            frame_count  <= frame_count_d;
            multi_hit    <= multi_hit_d;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_err  <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_pixel_combinator.sv
// Bench for pixel_combinator on a 4x2 frame with two queues; build with PIXEL_COMBINATOR_TIMEOUT_EN to cover the timeout path.
module tb_pixel_combinator;

    localparam int IW  = 4;
    localparam int IH  = 2;
    localparam int NQ  = 2;
    localparam int CW  = 24;
    localparam int DW  = 32;
    localparam int TMO = 8;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    localparam int LATE = 5;
`else
    localparam int LATE = 50;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NQ*CW-1:0]  colour_i;
    logic [NQ-1:0]     hit_i;
    logic [DW-1:0]     xpixel_check, ypixel_check;
    logic              check_valid;
    logic [CW-1:0]     colour_o;
    logic              out_valid, out_ready;
    logic              sop, eol, eop;
    logic [15:0]       frame_count;
    logic              multi_hit;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
    logic              timeout_err;
`endif

    pixel_combinator #(
        .DATA_WIDTH(DW), .RBG_SIZE(CW), .NUM_QUEUES(NQ),
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .TIMEOUT_CYCLES(TMO),
        .DEFAULT_COLOUR(24'h000000)
    ) dut (
        .clk(clk), .reset(reset), .colour_i(colour_i), .hit_i(hit_i),
        .xpixel_check(xpixel_check), .ypixel_check(ypixel_check),
        .check_valid(check_valid), .colour_o(colour_o), .out_valid(out_valid),
        .out_ready(out_ready), .sop(sop), .eol(eol), .eop(eop),
        .frame_count(frame_count), .multi_hit(multi_hit)
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] col;
        logic          sop;
        logic          eol;
        logic          eop;
    } exp_t;

    typedef struct {
        int            x;
        int            y;
        int            delay;
        logic [1:0]    mask;
        int            stall;
        logic [CW-1:0] exp_col;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_check(input int ex, input int ey);
        int n;
        n = 0;
        while (!check_valid && n < 64) begin
            step();
            n++;
        end
        chk("check_valid_seen", 32'(n < 64), 1);
        chk("xpixel_check", xpixel_check, ex);
        chk("ypixel_check", ypixel_check, ey);
    endtask

    task automatic serve(input int ex, input int ey, input int delay, input logic [1:0] mask,
                         input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                         input logic [CW-1:0] exp_col, input int stall);
        int   errs;
        logic exp_eol;
        exp_eol = (ex == IW - 1);
        wait_check(ex, ey);
        errs = 0;
        for (int i = 0; i < delay; i++) begin
            step();
            if (!check_valid || out_valid || xpixel_check != ex || ypixel_check != ey) errs++;
        end
        if (delay > 0) chk("late_hit_hold", errs, 0);
        out_ready = (stall == 0);
        hit_i     = mask;
        colour_i  = {c1, c0};
        sb.push_back('{exp_col, (ex == 0 && ey == 0), exp_eol, (ex == IW - 1 && ey == IH - 1)});
        step();
        hit_i    = '0;
        colour_i = '0;
        chk("out_valid_rise", out_valid, 1);
        if (stall > 0) begin
            errs = 0;
            for (int i = 0; i < stall; i++) begin
                hit_i    = 2'b01;
                colour_i = {24'h777777, 24'h777777};
                step();
                if (colour_o != exp_col || eol != exp_eol || !out_valid || check_valid) errs++;
            end
            hit_i    = '0;
            colour_i = '0;
            chk("backpressure_hold", errs, 0);
            out_ready = 1'b1;
        end
        step();
        chk("out_valid_drop", out_valid, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                chk("scoreboard_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("colour_o", colour_o, mon_e.col);
                    chk("sop", sop, mon_e.sop);
                    chk("eol", eol, mon_e.eol);
                    chk("eop", eop, mon_e.eop);
                end
            end else if (!out_valid) begin
                chk("markers_idle", {sop, eol, eop}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 0, 0,    2'b01, 0, 24'h000000};
        vecs[1] = '{1, 0, 0,    2'b10, 0, 24'h000001};
        vecs[2] = '{2, 0, 0,    2'b01, 5, 24'h000002};
        vecs[3] = '{3, 0, 0,    2'b10, 0, 24'h000003};
        vecs[4] = '{0, 1, 0,    2'b01, 0, 24'h000010};
        vecs[5] = '{1, 1, LATE, 2'b10, 0, 24'h000011};
        vecs[6] = '{2, 1, 0,    2'b01, 0, 24'h000012};
        vecs[7] = '{3, 1, 0,    2'b10, 0, 24'h000013};

        reset     = 1'b1;
        hit_i     = '0;
        colour_i  = '0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_check_valid", check_valid, 0);
        chk("rst_xpixel_check", xpixel_check, 0);
        chk("rst_ypixel_check", ypixel_check, 0);
        chk("rst_colour_o", colour_o, 0);
        chk("rst_markers", {sop, eol, eop}, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_multi_hit", multi_hit, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            serve(vecs[i].x, vecs[i].y, vecs[i].delay, vecs[i].mask,
                  vecs[i].mask[0] ? vecs[i].exp_col : 24'h5A5A5A,
                  vecs[i].mask[1] ? vecs[i].exp_col : 24'hA5A5A5,
                  vecs[i].exp_col, vecs[i].stall);
        end
        chk("frame_count_after_frame", frame_count, 1);
        chk("multi_hit_clear", multi_hit, 0);

        serve(0, 0, 0, 2'b11, 24'h0000AA, 24'h0000BB, 24'h0000AA, 0);
        chk("multi_hit_set", multi_hit, 1);
        serve(1, 0, 0, 2'b10, 24'h5A5A5A, 24'h000001, 24'h000001, 0);
        serve(2, 0, 0, 2'b01, 24'h000002, 24'hA5A5A5, 24'h000002, 0);
        serve(3, 0, 0, 2'b10, 24'h5A5A5A, 24'h000003, 24'h000003, 0);
        serve(0, 1, 0, 2'b01, 24'h000010, 24'hA5A5A5, 24'h000010, 0);
        chk("multi_hit_sticky", multi_hit, 1);

        wait_check(1, 1);
        out_ready = 1'b0;
        hit_i     = 2'b10;
        colour_i  = {24'h000011, 24'h5A5A5A};
        step();
        hit_i    = '0;
        colour_i = '0;
        chk("pre_reset_out_valid", out_valid, 1);
        reset = 1'b1;
        step();
        chk("reset_drops_out_valid", out_valid, 0);
        chk("reset_frame_count", frame_count, 0);
        chk("reset_multi_hit", multi_hit, 0);
        reset     = 1'b0;
        out_ready = 1'b1;

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        begin
            int n;
            wait_check(0, 0);
            chk("timeout_err_clear", timeout_err, 0);
            sb.push_back('{24'h000000, 1'b1, 1'b0, 1'b0});
            n = 0;
            while (!out_valid && n < 64) begin
                step();
                n++;
            end
            chk("timeout_latency", n, TMO);
            chk("timeout_err_set", timeout_err, 1);
            step();
            chk("timeout_out_valid_drop", out_valid, 0);
        end
`else
        serve(0, 0, 0, 2'b01, 24'h000000, 24'hA5A5A5, 24'h000000, 0);
`endif
        serve(1, 0, 0, 2'b10, 24'h5A5A5A, 24'h000001, 24'h000001, 0);
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
        chk("timeout_err_sticky", timeout_err, 1);
`endif
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
